// File: rtl/aib_rx_gearbox_if.sv
// Handshake/data bundle between the RX capture stage and the gearbox.
interface aib_rx_gearbox_if #(
  parameter int NUM_LANES = 4,
  parameter int RATIO     = 4
);
  localparam int DW = NUM_LANES * 2 * RATIO;

  logic [2:0]           rx_mode;
  logic [NUM_LANES-1:0] din0;
  logic [NUM_LANES-1:0] din1;
  logic                 bitslip;
  logic [DW-1:0]        dout;
  logic                 dout_vld;
  logic                 mode_ddr;
  logic                 mode_sdr;
  logic                 slip_busy;

  modport master (
    output rx_mode, din0, din1, bitslip,
    input  dout, dout_vld, mode_ddr, mode_sdr, slip_busy
  );

  modport slave (
    input  rx_mode, din0, din1, bitslip,
    output dout, dout_vld, mode_ddr, mode_sdr, slip_busy
  );
endinterface

// File: rtl/aib_rx_gearbox.sv
// Multi-lane RX deserialiser: packs SDR/DDR pad bits into wide words with
// bitslip and flush-on-mode-change. Per-lane shifters share one word counter.
module aib_rx_gearbox_lane #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         shift,
  input  logic         ddr,
  input  logic         din0,
  input  logic         din1,
  output logic [W-1:0] sr_nxt
);
  logic [W-1:0] sr;

  // New bits enter at the top so bit 0 always holds the oldest bit.
  always_comb begin
    sr_nxt = ddr ? (sr >> 2) : (sr >> 1);
    if (ddr) begin
      sr_nxt[W-1] = din1;
      sr_nxt[W-2] = din0;
    end else begin
      sr_nxt[W-1] = din0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        sr <= '0;
    else if (clr)   sr <= '0;
    else if (shift) sr <= sr_nxt;
  end
endmodule

module aib_rx_gearbox #(
  parameter int NUM_LANES = 4,
  parameter int RATIO     = 4
) (
  input  logic           clk,
  input  logic           rst,
  aib_rx_gearbox_if.slave bus
);
  localparam int W  = 2 * RATIO;
  localparam int DW = NUM_LANES * W;
  localparam int CW = $clog2(W);
  localparam logic [2:0]    MODE_DDR = 3'b001;
  localparam logic [2:0]    MODE_SDR = 3'b100;
  localparam logic [2:0]    MODE_DIS = 3'b010;
  localparam logic [CW-1:0] TERM_DDR = CW'(RATIO - 1);
  localparam logic [CW-1:0] TERM_SDR = CW'(W - 1);

  logic [2:0]                   mode_q;
  logic [CW-1:0]                cnt;
  logic [DW-1:0]                dout_q;
  logic                         vld_q, ddr_q, sdr_q, busy_q;
  logic                         mode_chg, gear, slip_acc, shift;
  logic [CW-1:0]                term;
  logic [NUM_LANES-1:0][W-1:0]  word_nxt;

  assign mode_chg = (bus.rx_mode != mode_q);
  assign gear     = ddr_q | sdr_q;
  assign shift    = gear & ~mode_chg;
  // A mode change on the same edge wins over a bitslip request.
  assign slip_acc = bus.bitslip & ~busy_q & shift;
  assign term     = ddr_q ? TERM_DDR : TERM_SDR;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    aib_rx_gearbox_lane #(.W(W)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .clr    (mode_chg),
      .shift  (shift),
      .ddr    (ddr_q),
      .din0   (bus.din0[l]),
      .din1   (bus.din1[l]),
      .sr_nxt (word_nxt[l])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= MODE_DIS;
      cnt    <= '0;
      dout_q <= '0;
      vld_q  <= 1'b0;
      ddr_q  <= 1'b0;
      sdr_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      if (mode_chg) begin
        mode_q <= bus.rx_mode;
        ddr_q  <= (bus.rx_mode == MODE_DDR);
        sdr_q  <= (bus.rx_mode == MODE_SDR);
        cnt    <= '0;
        busy_q <= 1'b0;
      end else if (!gear) begin
        cnt <= '0;
      end else if (slip_acc) begin
        // Data still shifts this edge; holding cnt moves the boundary later.
        busy_q <= 1'b1;
      end else if (cnt == term) begin
        cnt    <= '0;
        dout_q <= word_nxt;
        vld_q  <= 1'b1;
        busy_q <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign bus.dout      = dout_q;
  assign bus.dout_vld  = vld_q;
  assign bus.mode_ddr  = ddr_q;
  assign bus.mode_sdr  = sdr_q;
  assign bus.slip_busy = busy_q;
endmodule

// File: tb/tb_aib_rx_gearbox.sv
// Randomized bench for aib_rx_gearbox: a 1-lane RATIO=4 instance checked
// against a bit-stream reference model, plus a 4-lane RATIO=2 instance.
module tb_aib_rx_gearbox;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  aib_rx_gearbox_if #(.NUM_LANES(1), .RATIO(4)) ia ();
  aib_rx_gearbox_if #(.NUM_LANES(4), .RATIO(2)) ib ();

  aib_rx_gearbox #(.NUM_LANES(1), .RATIO(4)) u_a (.clk(clk), .rst(rst), .bus(ia));
  aib_rx_gearbox #(.NUM_LANES(4), .RATIO(2)) u_b (.clk(clk), .rst(rst), .bus(ib));

  initial forever #5 clk = ~clk;

  // Reference model: bits received since the last boundary, counted in bits.
  logic [2:0] m_mode;
  bit         bq[$];
  int         fill;
  logic       m_busy, m_vld;
  logic [7:0] m_dout;
  logic [11:0] exp_v, act_v;

  function automatic void model_reset();
    m_mode = 3'b010; bq.delete(); fill = 0; m_busy = 0; m_vld = 0; m_dout = 8'h00;
  endfunction

  function automatic void model_step(input logic [2:0] rm, input logic d0, input logic d1, input logic bs);
    bit ddr, gear;
    ddr  = (m_mode == 3'b001);
    gear = ddr || (m_mode == 3'b100);
    m_vld = 0;
    if (rm != m_mode) begin
      m_mode = rm; bq.delete(); fill = 0; m_busy = 0;
    end else if (gear) begin
      bq.push_back(d0);
      if (ddr) bq.push_back(d1);
      while (bq.size() > 8) void'(bq.pop_front());
      if (bs && !m_busy) m_busy = 1;
      else begin
        fill += ddr ? 2 : 1;
        if (fill == 8) begin
          for (int i = 0; i < 8; i++) m_dout[i] = bq[bq.size() - 8 + i];
          fill = 0; m_vld = 1; m_busy = 0;
        end
      end
    end
  endfunction

  task automatic tick(input logic [2:0] rm, input logic d0, input logic d1, input logic bs);
    ia.rx_mode = rm; ia.din0 = d0; ia.din1 = d1; ia.bitslip = bs;
    @(posedge clk);
    model_step(rm, d0, d1, bs);
    #1;
    exp_v = {m_dout, m_vld, m_busy, m_mode == 3'b001, m_mode == 3'b100};
    act_v = {ia.dout, ia.dout_vld, ia.slip_busy, ia.mode_ddr, ia.mode_sdr};
  endtask

  logic [3:0] pd0 = 4'b0011;
  logic [3:0] pd1 = 4'b1010;

  task automatic test_reset();
    rst = 1'b1;
    ia.rx_mode = 3'b010; ia.din0 = 0; ia.din1 = 0; ia.bitslip = 0;
    ib.rx_mode = 3'b010; ib.din0 = '0; ib.din1 = '0; ib.bitslip = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ia.dout, ia.dout_vld, ia.slip_busy, ia.mode_ddr, ia.mode_sdr} !== 12'h000) begin
      failures++; $display("FAIL reset_state got=%h exp=000", {ia.dout, ia.dout_vld, ia.slip_busy, ia.mode_ddr, ia.mode_sdr});
    end
    rst = 1'b0;
    tick(3'b001, 0, 0, 0);
    for (int i = 0; i < 7; i++) tick(3'b001, 1'($urandom), 1'($urandom), i == 5);
    #2 rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if ({ia.dout, ia.dout_vld, ia.slip_busy, ia.mode_ddr, ia.mode_sdr} !== 12'h000) begin
      failures++; $display("FAIL reset_async got=%h exp=000", {ia.dout, ia.dout_vld, ia.slip_busy, ia.mode_ddr, ia.mode_sdr});
    end
    @(posedge clk); #1;
    ia.rx_mode = 3'b010;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(3'b010, 1'($urandom), 1'($urandom), 1'($urandom));
      checks++;
      if (act_v !== exp_v || ia.dout_vld !== 1'b0) begin
        failures++; $display("FAIL reset_release got=%h exp=%h", act_v, exp_v);
      end
    end
  endtask

  task automatic test_ddr();
    tick(3'b001, 1, 1, 0);
    for (int w = 0; w < 3; w++)
      for (int p = 0; p < 4; p++) begin
        tick(3'b001, pd0[p], pd1[p], 0);
        checks++;
        if (act_v !== exp_v) begin
          failures++; $display("FAIL ddr_pattern got=%h exp=%h", act_v, exp_v);
        end
        if (p == 3) begin
          checks++;
          if (ia.dout !== 8'h8D || ia.dout_vld !== 1'b1) begin
            failures++; $display("FAIL ddr_word got=%h vld=%b exp=8d vld=1", ia.dout, ia.dout_vld);
          end
        end
      end
    for (int i = 0; i < 32; i++) begin
      tick(3'b001, 1'($urandom), 1'($urandom), 0);
      checks++;
      if (act_v !== exp_v) begin
        failures++; $display("FAIL ddr_random got=%h exp=%h", act_v, exp_v);
      end
    end
  endtask

  task automatic test_sdr();
    logic [7:0] sd0 = 8'h0F;
    tick(3'b100, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      tick(3'b100, sd0[i], 1'(i), 0);
      checks++;
      if (act_v !== exp_v) begin
        failures++; $display("FAIL sdr_pattern got=%h exp=%h", act_v, exp_v);
      end
    end
    checks++;
    if (ia.dout !== 8'h0F || ia.dout_vld !== 1'b1) begin
      failures++; $display("FAIL sdr_word got=%h vld=%b exp=0f vld=1", ia.dout, ia.dout_vld);
    end
    for (int i = 0; i < 40; i++) begin
      tick(3'b100, 1'($urandom), 1'($urandom), 0);
      checks++;
      if (act_v !== exp_v) begin
        failures++; $display("FAIL sdr_random got=%h exp=%h", act_v, exp_v);
      end
    end
  endtask

  task automatic test_bitslip();
    tick(3'b001, 0, 0, 0);
    for (int i = 0; i < 8; i++) tick(3'b001, pd0[i%4], pd1[i%4], 0);
    tick(3'b001, pd0[0], pd1[0], 0);
    tick(3'b001, pd0[1], pd1[1], 1);
    checks++;
    if (ia.slip_busy !== 1'b1 || act_v !== exp_v) begin
      failures++; $display("FAIL slip_busy got=%h exp=%h", act_v, exp_v);
    end
    tick(3'b001, pd0[2], pd1[2], 1);
    tick(3'b001, pd0[3], pd1[3], 0);
    checks++;
    if (ia.dout_vld !== 1'b0 || act_v !== exp_v) begin
      failures++; $display("FAIL slip_delay got=%h exp=%h", act_v, exp_v);
    end
    tick(3'b001, pd0[0], pd1[0], 0);
    checks++;
    if (ia.dout !== 8'h63 || ia.dout_vld !== 1'b1 || ia.slip_busy !== 1'b0) begin
      failures++; $display("FAIL slip_word got=%h vld=%b busy=%b exp=63 vld=1 busy=0", ia.dout, ia.dout_vld, ia.slip_busy);
    end
    for (int i = 0; i < 80; i++) begin
      tick((i < 40) ? 3'b001 : 3'b100, 1'($urandom), 1'($urandom), $urandom_range(0, 4) == 0);
      checks++;
      if (act_v !== exp_v) begin
        failures++; $display("FAIL slip_random got=%h exp=%h", act_v, exp_v);
      end
    end
  endtask

  task automatic test_mode_change();
    logic [7:0] held;
    tick(3'b001, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick(3'b001, 1'($urandom), 1'($urandom), 0);
    tick(3'b001, 1, 1, 0);
    tick(3'b001, 0, 1, 0);
    held = ia.dout;
    tick(3'b100, 1, 1, 0);
    checks++;
    if (ia.dout !== held || ia.dout_vld !== 1'b0 || ia.mode_sdr !== 1'b1) begin
      failures++; $display("FAIL mode_flush got=%h vld=%b exp=%h vld=0", ia.dout, ia.dout_vld, held);
    end
    for (int i = 0; i < 8; i++) begin
      tick(3'b100, 1'($urandom), 1'($urandom), 0);
      checks++;
      if (act_v !== exp_v || ia.dout_vld !== (i == 7)) begin
        failures++; $display("FAIL mode_first_sdr got=%h exp=%h", act_v, exp_v);
      end
    end
    held = ia.dout;
    for (int i = 0; i < 10; i++) begin
      tick(3'b010, 1'($urandom), 1'($urandom), 1'($urandom));
      checks++;
      if (ia.dout !== held || ia.dout_vld !== 1'b0 || act_v !== exp_v) begin
        failures++; $display("FAIL mode_disable got=%h exp=%h", act_v, exp_v);
      end
    end
    for (int i = 0; i < 150; i++) begin
      logic [2:0] rm;
      rm = ($urandom_range(0, 9) == 0) ? 3'($urandom) : ia.rx_mode;
      if ($urandom_range(0, 19) == 0) rm = ($urandom_range(0, 1) == 0) ? 3'b001 : 3'b100;
      tick(rm, 1'($urandom), 1'($urandom), $urandom_range(0, 5) == 0);
      checks++;
      if (act_v !== exp_v) begin
        failures++; $display("FAIL mode_random got=%h exp=%h", act_v, exp_v);
      end
    end
  endtask

  task automatic test_multilane();
    logic [3:0] d0 [2];
    logic [3:0] d1 [2];
    logic [3:0] exp_s;
    ib.rx_mode = 3'b001;
    tick(3'b010, 0, 0, 0);
    for (int w = 0; w < 6; w++)
      for (int c = 0; c < 2; c++) begin
        d0[c] = 4'($urandom); d1[c] = 4'($urandom);
        ib.din0 = d0[c]; ib.din1 = d1[c];
        tick(3'b010, 0, 0, 0);
        checks++;
        if (ib.dout_vld !== (c == 1)) begin
          failures++; $display("FAIL multi_vld got=%b exp=%b", ib.dout_vld, c == 1);
        end
        if (c == 1)
          for (int l = 0; l < 4; l++) begin
            exp_s = {d1[1][l], d0[1][l], d1[0][l], d0[0][l]};
            checks++;
            if (ib.dout[l*4 +: 4] !== exp_s) begin
              failures++; $display("FAIL multi_lane%0d got=%h exp=%h", l, ib.dout[l*4 +: 4], exp_s);
            end
          end
      end
  endtask

  initial begin
    test_reset();
    test_ddr();
    test_sdr();
    test_bitslip();
    test_mode_change();
    test_multilane();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/aib_rx_gearbox.md
Name: aib_rx_gearbox

Overview:
Parametrised multi-lane RX deserialiser that sits after the per-pad RX capture stage, in the distributed RX clock domain. It accepts the retimed per-lane bit pair (din0/din1) and decodes the same 3-bit RX mode field as the pad stage. In SDR or DDR mode it packs bits into wide words at a programmable gear ratio. It adds word-boundary bitslip and flush-on-mode-change, which the single-bit capture stage lacks.

Parameters:
NUM_LANES, 4, number of RX pad lanes
RATIO, 4, clk cycles per output word in DDR; power of 2, range 1..8
DW, NUM_LANES*2*RATIO, derived output width; not overridable

Ports:
clk  input  1  distributed RX clock; all logic on rising edge
rst  input  1  asynchronous, active-high reset
rx_mode  input  3  mode field: 3'b001 DDR, 3'b100 SDR, 3'b000 async, 3'b011 clock, 3'b010 disable; any other code is treated as disable
din0  input  NUM_LANES  per-lane older bit of the cycle
din1  input  NUM_LANES  per-lane newer bit of the cycle; DDR only
bitslip  input  1  single-cycle request to shift the word boundary
dout  output  DW  assembled word; lane l occupies dout[l*2*RATIO +: 2*RATIO], bit 0 of each slice is the oldest bit
dout_vld  output  1  one-cycle pulse when dout is updated
mode_ddr  output  1  registered decode: mode_q==3'b001
mode_sdr  output  1  registered decode: mode_q==3'b100
slip_busy  output  1  bitslip in progress; further requests ignored

Behaviour:
- Reset (async assert, sync release): mode_q=3'b010, shift registers=0, cnt=0, dout=0, dout_vld=0, mode_ddr=0, mode_sdr=0, slip_busy=0.
- Mode register: mode_q tracks rx_mode with 1-cycle latency.
- Mode change: at an edge where rx_mode!=mode_q:
  - mode_q<=rx_mode; cnt<=0; all shift registers<=0; slip_busy<=0; dout_vld<=0.
  - No data is shifted on that edge. dout keeps its last value. A partial word is discarded.
- Active gearing only when mode_q is DDR or SDR. In async, clock or disable mode: cnt=0, no shifting, dout_vld=0, dout holds.
- DDR: each edge, each lane shifts in din0 then din1 (2 bits per cycle). cnt counts 0..RATIO-1.
- SDR: each edge, each lane shifts in din0 only; din1 is ignored. cnt counts 0..2*RATIO-1.
- Word completion: on the edge where cnt reaches its terminal value:
  - dout<=completed word, including that edge's bits; dout_vld<=1 for exactly one cycle; cnt wraps to 0.
  - Steady state: one word every RATIO cycles (DDR) or every 2*RATIO cycles (SDR).
  - After a mode change, the first dout_vld is RATIO (DDR) or 2*RATIO (SDR) edges after the change edge.
- Bitslip:
  - Accepted when bitslip=1, slip_busy=0, and the mode is DDR/SDR.
  - On the next edge, data shifts but cnt does not advance. This moves the boundary later by 2 bits (DDR) or 1 bit (SDR).
  - slip_busy=1 from the edge after acceptance until the edge that issues the next dout_vld (cleared on that edge).
  - bitslip while busy, or in a non-gearing mode, is dropped.
  - A bitslip coinciding with a mode change is dropped; the mode change wins.
- Lanes are independent in data but share cnt, dout_vld and bitslip.
- Reset mid-word: all state clears immediately; no dout_vld is issued for the partial word.

Test Plan:
- Reset: assert rst mid-stream -> dout=0, dout_vld=0, slip_busy=0, mode_ddr=mode_sdr=0 asynchronously; after release with rx_mode=3'b010, still no dout_vld.
- DDR, NUM_LANES=1, RATIO=4: rx_mode=001, then (din0,din1)=(1,0),(1,1),(0,0),(0,1) over 4 cycles after the change edge -> dout=8'h8D with a single dout_vld pulse on the 4th edge; repeating the pattern gives dout_vld every 4 cycles.
- SDR, NUM_LANES=1, RATIO=4: rx_mode=100, din0=1,1,1,1,0,0,0,0 with din1 toggling -> dout=8'h0F after 8 edges; din1 has no effect.
- Bitslip, DDR, RATIO=4: pulse bitslip mid-word -> the next dout_vld comes 5 cycles after the previous one, and the word shifts by 2 bits (8'h8D stream becomes 8'h63). A second bitslip while slip_busy=1 changes nothing.
- Mode change mid-word: DDR, 2 cycles in, switch to SDR -> no dout_vld for the partial word, dout unchanged, first SDR word 8 edges later. Switching to 3'b010 stops dout_vld and holds dout.
- Multi-lane, NUM_LANES=4, RATIO=2: lane l drives a distinct pattern -> each 4-bit slice of the 16-bit dout matches its lane independently.
